fetch: RTL

- Instruction fetch stage that drives the `instruction` input of the decode stage in the decode/execute/writeback pipeline.
- Holds the PC and issues word reads to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO and presents one registered instruction per cycle; `stall` holds it, `redirect_valid` reloads the PC.
- Emits NOP_INSTR bubbles whenever no fetched instruction is available.

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Instruction-memory port of the fetch stage: a valid/ready request channel
// carrying a word address, and an in-order response channel with no
// backpressure. The fetch stage is the master; the memory is the slave.
interface fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage.
// Keeps the PC, issues word reads to instruction memory, buffers the in-order
// responses in a small FIFO and presents one registered instruction per cycle
// to decode. A credit check (requests in flight + buffered entries + stale
// responses still to be dropped) bounds outstanding work by FIFO_DEPTH, so
// the buffer can never overflow and responses never need backpressure.
// A redirect flushes everything; responses to requests issued before the
// redirect are counted in `discard` and dropped as they return.
module fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    fetch_if.master     imem,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    output logic        instruction_valid
);

    // Counters must represent 0..FIFO_DEPTH inclusive.
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    // Pointers wrap modulo FIFO_DEPTH (a power of two).
    localparam int PW = $clog2(FIFO_DEPTH);
    // The credit sum adds three counters; two spare bits keep it exact.
    localparam int SW = CW + 2;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [SW-1:0] sum_t;

    // One buffered fetch: the word and the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_q,          pc_d;          // next address to request
    logic [31:0] resp_pc_q,     resp_pc_d;     // address of next kept response
    cnt_t        in_flight_q,   in_flight_d;   // accepted, awaiting response
    cnt_t        discard_q,     discard_d;     // stale responses still to drop
    cnt_t        count_q,       count_d;       // FIFO occupancy
    ptr_t        wr_ptr_q,      wr_ptr_d;
    ptr_t        rd_ptr_q,      rd_ptr_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    entry_t      fifo_mem [FIFO_DEPTH];
    entry_t      head;

    // ------------------------------------------------------------------
    // Handshake and response classification
    // ------------------------------------------------------------------
    sum_t        credit_sum;
    logic        req_valid;
    logic        req_fire;
    logic        resp_keep;
    logic        resp_drop;
    logic        push;
    logic        pop;
    logic [31:0] redirect_target;

    assign credit_sum = sum_t'(in_flight_q) + sum_t'(count_q) + sum_t'(discard_q);

    // Forced low during reset; no request goes out in a redirect cycle so
    // the first new-PC request is issued from the freshly loaded PC.
    assign req_valid  = !reset && !redirect_valid && (credit_sum < sum_t'(FIFO_DEPTH));
    assign req_fire   = req_valid && imem.imem_req_ready;

    // A response is stale while any pre-redirect requests are outstanding.
    assign resp_drop  = imem.imem_resp_valid && (discard_q != '0);
    assign resp_keep  = imem.imem_resp_valid && (discard_q == '0);

    // A redirect flushes the FIFO, so nothing is written or read that cycle.
    assign push       = resp_keep && !redirect_valid;
    assign pop        = !redirect_valid && !stall && (count_q != '0);

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign head            = fifo_mem[rd_ptr_q];

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_q;

    assign instruction       = instr_q;
    assign instruction_pc    = instr_pc_q;
    assign instruction_valid = instr_valid_q;

    // ------------------------------------------------------------------
    // Next-state logic for PC, counters, FIFO pointers and output register
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        in_flight_d   = in_flight_q;
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (redirect_valid) begin
            // Redirect wins over stall: reload both PCs, flush the buffer and
            // the output register, and turn every outstanding request into a
            // response to drop. A response in this cycle settles against the
            // old discard count if one was pending, otherwise against
            // in_flight.
            pc_d          = redirect_target;
            resp_pc_d     = redirect_target;
            discard_d     = discard_q - cnt_t'(resp_drop) + in_flight_q - cnt_t'(resp_keep);
            in_flight_d   = '0;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            instr_d       = NOP_INSTR;
            instr_valid_d = 1'b0;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end

            in_flight_d = in_flight_q + cnt_t'(req_fire) - cnt_t'(resp_keep);
            discard_d   = discard_q - cnt_t'(resp_drop);

            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + ptr_t'(1);
            end

            // Output register advances only when decode can accept; the
            // head is read from state, so a word written this cycle is not
            // visible until the next one.
            if (!stall) begin
                if (count_q != '0) begin
                    instr_d       = head.data;
                    instr_pc_d    = head.pc;
                    instr_valid_d = 1'b1;
                    rd_ptr_d      = rd_ptr_q + ptr_t'(1);
                end else begin
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                end
            end

            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            in_flight_q   <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            in_flight_q   <= in_flight_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset; count_q marks which entries
        // are live, so stale contents are never observed.
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{pc: resp_pc_q, data: imem.imem_resp_data};
        end
    end

endmodule
